// File: rtl/ship_draw_pkg.sv
// Shared types and constants for the battleship board renderer.
package ship_pkg;

  typedef enum logic [1:0] {
    SHIP  = 2'd0,
    EMPTY = 2'd1,
    HIT   = 2'd2,
    MISS  = 2'd3
  } cell_state_t;

  localparam int CELL_SIZE   = 32;
  localparam int BOARD_CELLS = 10;
  localparam int BOARD_PX    = 320;

  // Enum literals already own the plain names, so colours carry an RGB_ prefix.
  localparam logic [11:0] RGB_SHIP  = 12'h888;
  localparam logic [11:0] RGB_EMPTY = 12'h6AF;
  localparam logic [11:0] RGB_HIT   = 12'hF00;
  localparam logic [11:0] RGB_MISS  = 12'hFFF;
  localparam logic [11:0] RGB_WATER = 12'h138;
  localparam logic [11:0] RGB_GRID  = 12'h000;

endpackage

// File: rtl/ship_draw_board_mem.sv
// 10x10 board state register file: synchronous clear/write, combinational read.
module ship_board_mem
  import ship_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        we_i,
  input  logic [3:0]  wr_x_i,
  input  logic [3:0]  wr_y_i,
  input  cell_state_t wr_state_i,
  input  logic [3:0]  rd_x_i,
  input  logic [3:0]  rd_y_i,
  output cell_state_t rd_state_o
);

  cell_state_t cells_q [BOARD_CELLS*BOARD_CELLS];

  logic [7:0] wr_idx;
  logic [7:0] rd_idx;
  logic       wr_ok;

  assign wr_idx = 8'(wr_y_i) * 8'd10 + 8'(wr_x_i);
  assign rd_idx = 8'(rd_y_i) * 8'd10 + 8'(rd_x_i);
  assign wr_ok  = we_i && (wr_x_i < 4'd10) && (wr_y_i < 4'd10);

  // Out-of-board lookups may form indices past 99; report EMPTY for those.
  assign rd_state_o = (rd_idx < 8'd100) ? cells_q[rd_idx[6:0]] : EMPTY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BOARD_CELLS*BOARD_CELLS; i++) cells_q[i] <= EMPTY;
    end else if (clr_i) begin
      for (int i = 0; i < BOARD_CELLS*BOARD_CELLS; i++) cells_q[i] <= EMPTY;
    end else if (wr_ok) begin
      cells_q[wr_idx[6:0]] <= wr_state_i;
    end
  end

endmodule

// File: rtl/ship_draw.sv
// Battleship board overlay: 3-stage pixel pipeline with an external 1-clock bitmap ROM.
// Optional grid lines are enabled by defining SHIP_DRAW_GRID_EN.
module ship_draw
  import ship_pkg::*;
#(
  parameter int BOARD_X = 100,
  parameter int BOARD_Y = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        cell_we,
  input  logic [3:0]  cell_x,
  input  logic [3:0]  cell_y,
  input  logic [1:0]  cell_state,
  input  logic        board_clr,
  output logic [6:0]  rom_addr,
  input  logic [31:0] ship_line_pixels_in,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  function automatic logic [11:0] state_rgb(input cell_state_t s);
    case (s)
      SHIP:    state_rgb = RGB_SHIP;
      EMPTY:   state_rgb = RGB_EMPTY;
      HIT:     state_rgb = RGB_HIT;
      default: state_rgb = RGB_MISS;
    endcase
  endfunction

  // Only the low 9 bits of the offsets are ever consumed (cell index + in-cell offset).
  logic [8:0]  dx, dy;
  logic        in_board;
  cell_state_t rd_state;
  logic [6:0]  rom_addr_d;

  assign dx = 9'(hcount_in - 11'(BOARD_X));
  assign dy = 9'(vcount_in - 11'(BOARD_Y));
  assign in_board = (hcount_in >= 11'(BOARD_X)) && (hcount_in < 11'(BOARD_X + BOARD_PX)) &&
                    (vcount_in >= 11'(BOARD_Y)) && (vcount_in < 11'(BOARD_Y + BOARD_PX));
  assign rom_addr_d = in_board ? {rd_state, dy[4:0]} : 7'h20;

  ship_board_mem u_board_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (board_clr),
    .we_i       (cell_we),
    .wr_x_i     (cell_x),
    .wr_y_i     (cell_y),
    .wr_state_i (cell_state_t'(cell_state)),
    .rd_x_i     (dx[8:5]),
    .rd_y_i     (dy[8:5]),
    .rd_state_o (rd_state)
  );

  logic [10:0] hcount_p1_q, vcount_p1_q, hcount_p2_q, vcount_p2_q;
  logic        hsync_p1_q, vsync_p1_q, hblnk_p1_q, vblnk_p1_q;
  logic        hsync_p2_q, vsync_p2_q, hblnk_p2_q, vblnk_p2_q;
  logic [11:0] rgb_p1_q, rgb_p2_q;
  logic        in_board_p1_q, in_board_p2_q;
  logic [4:0]  col_p1_q, row_p1_q, col_p2_q, row_p2_q;
  cell_state_t state_p1_q, state_p2_q;

  // Stage 1: board lookup and ROM address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr      <= 7'h00;
      hcount_p1_q   <= '0;
      vcount_p1_q   <= '0;
      hsync_p1_q    <= 1'b0;
      vsync_p1_q    <= 1'b0;
      hblnk_p1_q    <= 1'b0;
      vblnk_p1_q    <= 1'b0;
      rgb_p1_q      <= '0;
      in_board_p1_q <= 1'b0;
      col_p1_q      <= '0;
      row_p1_q      <= '0;
      state_p1_q    <= SHIP;
    end else begin
      rom_addr      <= rom_addr_d;
      hcount_p1_q   <= hcount_in;
      vcount_p1_q   <= vcount_in;
      hsync_p1_q    <= hsync_in;
      vsync_p1_q    <= vsync_in;
      hblnk_p1_q    <= hblnk_in;
      vblnk_p1_q    <= vblnk_in;
      rgb_p1_q      <= rgb_in;
      in_board_p1_q <= in_board;
      col_p1_q      <= dx[4:0];
      row_p1_q      <= dy[4:0];
      state_p1_q    <= rd_state;
    end
  end

  // Stage 2: wait for the ROM output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_p2_q   <= '0;
      vcount_p2_q   <= '0;
      hsync_p2_q    <= 1'b0;
      vsync_p2_q    <= 1'b0;
      hblnk_p2_q    <= 1'b0;
      vblnk_p2_q    <= 1'b0;
      rgb_p2_q      <= '0;
      in_board_p2_q <= 1'b0;
      col_p2_q      <= '0;
      row_p2_q      <= '0;
      state_p2_q    <= SHIP;
    end else begin
      hcount_p2_q   <= hcount_p1_q;
      vcount_p2_q   <= vcount_p1_q;
      hsync_p2_q    <= hsync_p1_q;
      vsync_p2_q    <= vsync_p1_q;
      hblnk_p2_q    <= hblnk_p1_q;
      vblnk_p2_q    <= vblnk_p1_q;
      rgb_p2_q      <= rgb_p1_q;
      in_board_p2_q <= in_board_p1_q;
      col_p2_q      <= col_p1_q;
      row_p2_q      <= row_p1_q;
      state_p2_q    <= state_p1_q;
    end
  end

`ifdef SHIP_DRAW_GRID_EN
  // Grid covers the first pixel of every cell plus the far board edge at offset 319.
  logic grid_p1_q, grid_p2_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grid_p1_q <= 1'b0;
      grid_p2_q <= 1'b0;
    end else begin
      grid_p1_q <= (dx[4:0] == 5'd0) || (dy[4:0] == 5'd0) || (dx == 9'd319) || (dy == 9'd319);
      grid_p2_q <= grid_p1_q;
    end
  end
`endif

  logic        pix;
  logic [11:0] rgb_d;

  // MSB of the ROM line is the leftmost pixel of the cell.
  assign pix = ship_line_pixels_in[5'd31 - col_p2_q];

  always_comb begin
    rgb_d = RGB_WATER;
    if (hblnk_p2_q || vblnk_p2_q)  rgb_d = 12'h000;
    else if (!in_board_p2_q)       rgb_d = rgb_p2_q;
`ifdef SHIP_DRAW_GRID_EN
    else if (grid_p2_q)            rgb_d = RGB_GRID;
`endif
    else if (pix)                  rgb_d = state_rgb(state_p2_q);
    else                           rgb_d = RGB_WATER;
  end

  // Stage 3: colour select and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= 12'h000;
    end else begin
      hcount_out <= hcount_p2_q;
      vcount_out <= vcount_p2_q;
      hsync_out  <= hsync_p2_q;
      vsync_out  <= vsync_p2_q;
      hblnk_out  <= hblnk_p2_q;
      vblnk_out  <= vblnk_p2_q;
      rgb_out    <= rgb_d;
    end
  end

endmodule

// File: tb/tb_ship_draw.sv
// Self-checking bench for ship_draw: directed board scenarios plus randomized pixels/writes.
module tb_ship_draw;

  localparam int BX = 100;
  localparam int BY = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic        cell_we = 1'b0, board_clr = 1'b0;
  logic [3:0]  cell_x = '0, cell_y = '0;
  logic [1:0]  cell_state = '0;
  logic [6:0]  rom_addr;
  logic [31:0] rom_line = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  ship_draw #(.BOARD_X(BX), .BOARD_Y(BY)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .hcount_in           (hcount_in),
    .vcount_in           (vcount_in),
    .hsync_in            (hsync_in),
    .vsync_in            (vsync_in),
    .hblnk_in            (hblnk_in),
    .vblnk_in            (vblnk_in),
    .rgb_in              (rgb_in),
    .cell_we             (cell_we),
    .cell_x              (cell_x),
    .cell_y              (cell_y),
    .cell_state          (cell_state),
    .board_clr           (board_clr),
    .rom_addr            (rom_addr),
    .ship_line_pixels_in (rom_line),
    .hcount_out          (hcount_out),
    .vcount_out          (vcount_out),
    .hsync_out           (hsync_out),
    .vsync_out           (vsync_out),
    .hblnk_out           (hblnk_out),
    .vblnk_out           (vblnk_out),
    .rgb_out             (rgb_out)
  );

  always #5 clk = ~clk;

  // Bitmap ROM with one clock of read latency.
  logic [31:0] rom [128];
  always @(posedge clk) rom_line <= rom[rom_addr];

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } exp_t;

  exp_t exp_q[$];
  int   board_m [100];
  int   rom_exp;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, want);
    end
  endtask

  function automatic bit inside_board(input int h, input int v);
    return h >= BX && h < BX + 320 && v >= BY && v < BY + 320;
  endfunction

  function automatic int model_rom(input int h, input int v);
    if (!inside_board(h, v)) return 32;
    return board_m[((v - BY) / 32) * 10 + (h - BX) / 32] * 32 + (v - BY) % 32;
  endfunction

  function automatic logic [11:0] model_rgb(input int h, input int v, input bit hb,
                                            input bit vb, input logic [11:0] bg);
    int ox, oy, st;
    logic [31:0] line;
    if (hb || vb) return 12'h000;
    if (!inside_board(h, v)) return bg;
    ox = h - BX;
    oy = v - BY;
`ifdef SHIP_DRAW_GRID_EN
    if (ox % 32 == 0 || oy % 32 == 0 || ox == 319 || oy == 319) return 12'h000;
`endif
    st   = board_m[(oy / 32) * 10 + ox / 32];
    line = rom[st * 32 + oy % 32];
    if (line[31 - ox % 32] == 1'b0) return 12'h138;
    case (st)
      0:       return 12'h888;
      1:       return 12'h6AF;
      2:       return 12'hF00;
      default: return 12'hFFF;
    endcase
  endfunction

  task automatic drive_push(input int h, input int v, input bit hs, input bit vs, input bit hb,
                            input bit vb, input logic [11:0] bg, input bit we, input int x,
                            input int y, input int st, input bit clr);
    exp_t e;
    hcount_in = 11'(h); vcount_in = 11'(v);
    hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb;
    rgb_in = bg;
    cell_we = we; cell_x = 4'(x); cell_y = 4'(y); cell_state = 2'(st); board_clr = clr;
    e.hc = 11'(h); e.vc = 11'(v);
    e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb;
    e.rgb = model_rgb(h, v, hb, vb, bg);
    exp_q.push_back(e);
    rom_exp = model_rom(h, v);
    // The lookup for this pixel sees the board before this cycle's write lands.
    if (clr) begin
      for (int i = 0; i < 100; i++) board_m[i] = 1;
    end else if (we && x < 10 && y < 10) begin
      board_m[y * 10 + x] = st;
    end
  endtask

  task automatic check_out();
    exp_t e;
    chk("rom_addr", 32'(rom_addr), 32'(rom_exp));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("hcount", 32'(hcount_out), 32'(e.hc));
      chk("vcount", 32'(vcount_out), 32'(e.vc));
      chk("sync", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}),
          32'({e.hs, e.vs, e.hb, e.vb}));
      chk("rgb", 32'(rgb_out), 32'(e.rgb));
    end
  endtask

  task automatic cyc(input int h, input int v, input bit hs, input bit vs, input bit hb,
                     input bit vb, input logic [11:0] bg, input bit we, input int x,
                     input int y, input int st, input bit clr);
    @(negedge clk);
    check_out();
    drive_push(h, v, hs, vs, hb, vb, bg, we, x, y, st, clr);
  endtask

  task automatic px(input int h, input int v, input logic [11:0] bg);
    cyc(h, v, 1'b0, 1'b0, 1'b0, 1'b0, bg, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic idle();
    px(0, 0, 12'(($urandom)));
  endtask

  task automatic wr(input int x, input int y, input int st, input bit clr);
    cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, x, y, st, clr);
  endtask

  task automatic release_reset();
    exp_t z;
    z = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) board_m[i] = 1;
    exp_q.delete();
    exp_q.push_back(z);
    exp_q.push_back(z);
    drive_push(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'h0);
    chk(tag, 32'(rgb_out), 32'h0);
    chk(tag, 32'(rom_addr), 32'h0);
  endtask

  logic [11:0] want_water;
  logic [11:0] want_col0;

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = $urandom;
    rom[7'h07] = 32'hFFFF_FFFF;
    rom[7'h41] = 32'h01C0_0380;
    rom[7'h20] = 32'h0000_0000;
`ifdef SHIP_DRAW_GRID_EN
    want_water = 12'h000;
    want_col0  = 12'h000;
`else
    want_water = 12'h138;
    want_col0  = 12'h138;
`endif

    // Hold reset with activity on the inputs.
    hcount_in = 11'd150; vcount_in = 11'd150; rgb_in = 12'hABC; hsync_in = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    release_reset();

    // Empty board, first board pixel.
    px(100, 100, 12'h555);
    idle();
    chk("tp_rom_empty", 32'(rom_addr), 32'h20);
    idle(); idle();
    chk("tp_rgb_water", 32'(rgb_out), 32'(want_water));
    chk("tp_hcount", 32'(hcount_out), 32'd100);

    // SHIP at (2,3), full ROM line.
    wr(2, 3, 0, 1'b0);
    px(169, 203, 12'h555);
    idle();
    chk("tp_rom_ship", 32'(rom_addr), 32'h07);
    idle(); idle();
    chk("tp_rgb_ship", 32'(rgb_out), 32'h888);

    // HIT at (0,0), row 1, columns 7 and 0.
    wr(0, 0, 2, 1'b0);
    px(107, 101, 12'h555);
    px(100, 101, 12'h555);
    idle(); idle();
    chk("tp_rgb_hit", 32'(rgb_out), 32'hF00);
    idle();
    chk("tp_rgb_hit_col0", 32'(rgb_out), 32'(want_col0));

    // Outside the board: passthrough.
    px(99, 150, 12'hABC);
    idle(); idle(); idle();
    chk("tp_left_out", 32'(rgb_out), 32'hABC);
    px(420, 150, 12'h123);
    idle(); idle(); idle();
    chk("tp_right_out", 32'(rgb_out), 32'h123);

    // Out-of-range writes must not alias onto real cells.
    wr(10, 0, 2, 1'b0);
    wr(0, 10, 3, 1'b0);
    px(105, 133, 12'h555);
    idle();
    chk("tp_oob_write", 32'(rom_addr), 32'h21);
    px(105, 100, 12'h555);
    idle();
    chk("tp_hit_kept", 32'(rom_addr), 32'h40);

    // Clear beats a same-cycle write.
    wr(5, 5, 2, 1'b1);
    px(263, 262, 12'h555);
    idle();
    chk("tp_clr_wins", 32'(rom_addr), 32'h22);

    // Board edges and blanking.
    px(419, 150, 12'h111); px(420, 150, 12'h222); px(150, 419, 12'h333);
    px(150, 420, 12'h444); px(100, 99, 12'h666);  px(99, 100, 12'h777);
    cyc(200, 200, 1'b1, 1'b0, 1'b1, 1'b0, 12'hFFF, 1'b0, 0, 0, 0, 1'b0);
    cyc(200, 200, 1'b0, 1'b1, 1'b0, 1'b1, 12'hFFF, 1'b0, 0, 0, 0, 1'b0);

    // Grid pixel at a cell's left edge.
    px(132, 140, 12'h555);
    idle(); idle(); idle();
`ifdef SHIP_DRAW_GRID_EN
    chk("tp_grid", 32'(rgb_out), 32'h000);
`endif

    // Randomized pixels interleaved with writes and occasional clears.
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(90, 430), $urandom_range(90, 430), 1'($urandom), 1'($urandom),
          ($urandom % 8) == 0, ($urandom % 8) == 0, 12'($urandom),
          ($urandom % 4) == 0, $urandom_range(0, 11), $urandom_range(0, 11),
          $urandom_range(0, 3), ($urandom % 97) == 0);
    end

    // Asynchronous reset mid-line clears outputs and board at once.
    wr(2, 3, 0, 1'b0);
    for (int n = 0; n < 5; n++) px(150 + n, 200, 12'h5A5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    release_reset();
    px(169, 203, 12'h555);
    idle();
    chk("tp_board_reset", 32'(rom_addr), 32'h27);

    for (int n = 0; n < 200; n++) begin
      cyc($urandom_range(90, 430), $urandom_range(90, 430), 1'b0, 1'b0, 1'b0, 1'b0,
          12'($urandom), ($urandom % 3) == 0, $urandom_range(0, 10), $urandom_range(0, 10),
          $urandom_range(0, 3), 1'b0);
    end
    repeat (3) idle();
    @(negedge clk);
    check_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
